stream_mode_finder: RTL and testbench
=====================================

// Module: stream_mode_finder
// PURPOSE
//  Streaming mode (most-frequent-symbol) detector. Accepts SYM_W-bit symbols over a
//  valid/ready stream and builds a per-value histogram for a frame of up to FRAME_LEN
//  symbols. At frame end it reports the winning value, its count, the frame length
//  and a tie flag. Sits between symbol decoders and majority-vote/decision logic.
// PARAMETERS
//  SYM_W      2   symbol width; 1..4; number of bins NB = 2**SYM_W
//  FRAME_LEN  8   max symbols per frame; 2..255
//  CNT_W      $clog2(FRAME_LEN+1)   bin/count width (derived, not overridden)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  clr        in   1      sync abort: drop current frame/result, return to ACCUM
//  in_valid   in   1      input symbol valid
//  in_ready   out  1      block can accept a symbol (high only in ACCUM)
//  in_data    in   SYM_W  input symbol
//  in_last    in   1      marks final symbol of a short frame
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      downstream accepts result
//  out_mode   out  SYM_W  most frequent value; lowest value wins ties
//  out_count  out  CNT_W  occurrences of out_mode
//  out_len    out  CNT_W  symbols in the frame (1..FRAME_LEN)
//  out_tie    out  1      another value has the same count as out_mode
// BEHAVIOUR
//  - Reset: state=ACCUM, all bins=0, len=0, out_valid=0, out_mode=0, out_count=0,
//    out_len=0, out_tie=0; in_ready=1 immediately after reset release.
//  - FSM ACCUM -> SCAN -> DONE -> ACCUM. in_ready = (state==ACCUM).
//  - ACCUM: on in_valid&in_ready, bin[in_data]++ and len++. When the accepted symbol
//    has in_last=1 or makes len==FRAME_LEN, go to SCAN. in_last on any accepted symbol
//    ends the frame; in_last without in_valid is ignored. Bins never overflow.
//  - SCAN: index i=0..NB-1, one bin per cycle; best_cnt/best start at 0.
//    bin[i] > best_cnt : best=i, best_cnt=bin[i], tie=0.
//    bin[i]==best_cnt && bin[i]!=0 : tie=1. Strict compare => lowest value wins.
//  - DONE: out_valid=1 on the edge completing step i=NB-1, i.e. NB edges after the
//    edge that accepted the final symbol. Outputs stable while out_valid&!out_ready.
//  - out_valid&out_ready: bins and len cleared, out_valid=0, state=ACCUM on that edge;
//    in_ready high next cycle (one bubble cycle, no same-cycle input acceptance).
//  - clr (any state): same edge clears bins, len, out_valid, tie and enters ACCUM;
//    a symbol presented in the clr cycle is not counted; clr beats in_valid/out_ready.
//  - rst_n low mid-frame or mid-result: asynchronous return to reset values; the
//    partial frame is lost, no result emitted.
//  - Widths: bins/len are CNT_W unsigned; comparisons unsigned; no saturation needed.
// STRUCTURE
//  - Package stream_mode_pkg: state enum {ACCUM,SCAN,DONE}, NB/CNT_W derivation
//    constants, parameter range checks.
//  - Sub-module mode_hist_bank: NB x CNT_W counters with inc(idx), clear, and read
//    port rd_idx -> rd_cnt used by the SCAN step. Top holds FSM, len, scan index and
//    result registers.
// TESTING
//  - Full frame SYM_W=2,FRAME_LEN=8: 3,1,1,2,1,0,3,1 -> mode=1,count=4,len=8,tie=0;
//    out_valid 4 cycles after the final acceptance.
//  - Tie: 0,2,2,0,3,3,1,1 -> mode=0,count=2,tie=1 (lowest value wins).
//  - Short frame: 2,2,3 with in_last on 3 -> mode=2,count=2,len=3,tie=0.
//  - Backpressure: hold out_ready=0 10 cycles -> outputs stable, in_ready=0 throughout;
//    next frame starts with bins at zero.
//  - clr after 5 symbols, then frame of eight 3s -> mode=3,count=8; no stale counts.
//  - rst_n pulse mid-SCAN -> out_valid never rises; all outputs at reset values;
//    repeat with SYM_W=3,FRAME_LEN=20 (scan = 8 cycles) for random frames vs model.

Source files
------------

// File: rtl/stream_mode_pkg.sv
// Shared constants and helpers for the streaming mode finder.
// Holds FSM encodings, width derivations and the parameter legality check.
package stream_mode_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StAccum = 2'd0;
    localparam state_t StScan  = 2'd1;
    localparam state_t StDone  = 2'd2;

    function automatic int unsigned calc_nb(input int unsigned sym_w);
        return 32'd1 << sym_w;
    endfunction

    function automatic int unsigned calc_cnt_w(input int unsigned frame_len);
        return $clog2(frame_len + 1);
    endfunction

    function automatic bit params_ok(input int unsigned sym_w, input int unsigned frame_len);
        return (sym_w >= 1) && (sym_w <= 4) && (frame_len >= 2) && (frame_len <= 255);
    endfunction

endpackage

// File: rtl/mode_hist_bank.sv
// Bank of NB per-value counters with increment, clear and a single read port.
// Clear wins over increment in the same cycle.
module mode_hist_bank
    import stream_mode_pkg::*;
#(
    parameter int unsigned SYM_W = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [SYM_W-1:0] inc_idx,
    input  logic [SYM_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_cnt
);

    localparam int unsigned NB = calc_nb(SYM_W);

    logic [CNT_W-1:0] bin_q [NB];
    logic [CNT_W-1:0] bin_d [NB];

    always_comb begin
        bin_d = bin_q;
        if (clr) begin
            for (int i = 0; i < int'(NB); i++) begin
                bin_d[i] = '0;
            end
        end else if (inc) begin
            bin_d[inc_idx] = bin_q[inc_idx] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NB); i++) begin
                bin_q[i] <= '0;
            end
        end else begin
            bin_q <= bin_d;
        end
    end

    assign rd_cnt = bin_q[rd_idx];

endmodule

// File: rtl/stream_mode_finder.sv
// Streaming most-frequent-symbol detector: accumulate a frame into a histogram,
// scan one bin per cycle for the winner, then hold the result until accepted.
module stream_mode_finder
    import stream_mode_pkg::*;
#(
    parameter int unsigned SYM_W     = 2,
    parameter int unsigned FRAME_LEN = 8,
    localparam int unsigned CNT_W    = calc_cnt_w(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_mode,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] out_len,
    output logic             out_tie
);

    localparam int unsigned NB = calc_nb(SYM_W);

    if (!params_ok(SYM_W, FRAME_LEN)) begin : g_bad_params
        $error("stream_mode_finder: SYM_W must be 1..4 and FRAME_LEN 2..255");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [SYM_W-1:0] idx_q, idx_d;
    logic [SYM_W-1:0] best_q, best_d;
    logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
    logic             tie_q, tie_d;

    logic             accept;
    logic             hist_clr;
    logic             hist_inc;
    logic [CNT_W-1:0] rd_cnt;

    assign in_ready = (state_q == StAccum);
    assign accept   = in_valid & in_ready;
    // Bins are wiped on abort and on result handoff so the next frame starts clean.
    assign hist_clr = clr | ((state_q == StDone) & out_ready);
    assign hist_inc = accept & ~clr;

    mode_hist_bank #(
        .SYM_W (SYM_W),
        .CNT_W (CNT_W)
    ) u_hist (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (hist_clr),
        .inc     (hist_inc),
        .inc_idx (in_data),
        .rd_idx  (idx_q),
        .rd_cnt  (rd_cnt)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_cnt_d = best_cnt_q;
        tie_d      = tie_q;

        if (clr) begin
            state_d    = StAccum;
            len_d      = '0;
            idx_d      = '0;
            best_d     = '0;
            best_cnt_d = '0;
            tie_d      = 1'b0;
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (accept) begin
                        len_d = len_q + CNT_W'(1);
                        if (in_last || (len_d == CNT_W'(FRAME_LEN))) begin
                            state_d    = StScan;
                            idx_d      = '0;
                            best_d     = '0;
                            best_cnt_d = '0;
                            tie_d      = 1'b0;
                        end
                    end
                end
                StScan: begin
                    // Strict greater-than keeps the lowest value on equal counts.
                    if (rd_cnt > best_cnt_q) begin
                        best_d     = idx_q;
                        best_cnt_d = rd_cnt;
                        tie_d      = 1'b0;
                    end else if ((rd_cnt == best_cnt_q) && (rd_cnt != '0)) begin
                        tie_d = 1'b1;
                    end
                    idx_d = idx_q + SYM_W'(1);
                    if (idx_q == SYM_W'(NB - 1)) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d    = StAccum;
                        len_d      = '0;
                        best_d     = '0;
                        best_cnt_d = '0;
                        tie_d      = 1'b0;
                    end
                end
                default: begin
                    state_d = StAccum;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StAccum;
            len_q      <= '0;
            idx_q      <= '0;
            best_q     <= '0;
            best_cnt_q <= '0;
            tie_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_cnt_q <= best_cnt_d;
            tie_q      <= tie_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign out_mode  = best_q;
    assign out_count = best_cnt_q;
    assign out_len   = len_q;
    assign out_tie   = tie_q;

endmodule

// File: tb/tb_stream_mode_finder.sv
// Scoreboard bench for stream_mode_finder: a 2-bit/8-symbol instance and a
// 3-bit/20-symbol instance share stimulus, selected by the big flag.
module tb_stream_mode_finder;

    typedef struct {
        int mode;
        int count;
        int len;
        int tie;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    bit         big;
    logic       clr;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic [2:0] in_data;

    logic       a_in_ready, a_out_valid, a_out_tie;
    logic [1:0] a_out_mode;
    logic [3:0] a_out_count, a_out_len;
    logic       b_in_ready, b_out_valid, b_out_tie;
    logic [2:0] b_out_mode;
    logic [4:0] b_out_count, b_out_len;

    logic       obs_ready, obs_valid, obs_tie;
    int         obs_mode, obs_count, obs_len;

    res_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         nb = 4;

    always #5 clk = ~clk;

    stream_mode_finder #(
        .SYM_W     (2),
        .FRAME_LEN (8)
    ) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr & ~big),
        .in_valid  (in_valid & ~big),
        .in_ready  (a_in_ready),
        .in_data   (in_data[1:0]),
        .in_last   (in_last),
        .out_valid (a_out_valid),
        .out_ready (out_ready & ~big),
        .out_mode  (a_out_mode),
        .out_count (a_out_count),
        .out_len   (a_out_len),
        .out_tie   (a_out_tie)
    );

    stream_mode_finder #(
        .SYM_W     (3),
        .FRAME_LEN (20)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr & big),
        .in_valid  (in_valid & big),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (b_out_valid),
        .out_ready (out_ready & big),
        .out_mode  (b_out_mode),
        .out_count (b_out_count),
        .out_len   (b_out_len),
        .out_tie   (b_out_tie)
    );

    always_comb begin
        obs_ready = big ? b_in_ready  : a_in_ready;
        obs_valid = big ? b_out_valid : a_out_valid;
        obs_tie   = big ? b_out_tie   : a_out_tie;
        obs_mode  = big ? int'(b_out_mode)  : int'(a_out_mode);
        obs_count = big ? int'(b_out_count) : int'(a_out_count);
        obs_len   = big ? int'(b_out_len)   : int'(a_out_len);
    end

    function automatic res_t model(input int syms[$]);
        int   h[16];
        res_t r;
        h = '{default: 0};
        foreach (syms[i]) h[syms[i]]++;
        r = '{mode: 0, count: 0, len: syms.size(), tie: 0};
        for (int v = 0; v < nb; v++) begin
            if (h[v] > r.count) begin
                r.mode  = v;
                r.count = h[v];
                r.tie   = 0;
            end else if (h[v] == r.count && h[v] != 0) begin
                r.tie = 1;
            end
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_sym(input int v, input bit last);
        int t = 0;
        in_valid = 1'b1;
        in_data  = 3'(v);
        in_last  = last;
        while (!obs_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!obs_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got=%0b want=1", obs_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int syms[$], input bit use_last);
        sb.push_back(model(syms));
        foreach (syms[i]) send_sym(syms[i], use_last && (i == syms.size() - 1));
    endtask

    task automatic collect(input bit check_lat, input string name);
        int   k = 0;
        res_t e;
        while (!obs_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!obs_valid) begin
            errors++;
            $display("FAIL %s out_valid_timeout got=0 want=1", name);
            return;
        end
        if (check_lat) begin
            checks++;
            if (k !== nb) begin
                errors++;
                $display("FAIL %s latency got=%0d want=%0d", name, k, nb);
            end
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty got=result want=none", name);
            return;
        end
        e = sb.pop_front();
        checks += 5;
        if (obs_mode !== e.mode) begin
            errors++;
            $display("FAIL %s mode got=%0d want=%0d", name, obs_mode, e.mode);
        end
        if (obs_count !== e.count) begin
            errors++;
            $display("FAIL %s count got=%0d want=%0d", name, obs_count, e.count);
        end
        if (obs_len !== e.len) begin
            errors++;
            $display("FAIL %s len got=%0d want=%0d", name, obs_len, e.len);
        end
        if (int'(obs_tie) !== e.tie) begin
            errors++;
            $display("FAIL %s tie got=%0d want=%0d", name, obs_tie, e.tie);
        end
        if (obs_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready_in_done got=%0b want=0", name, obs_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks += 2;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s valid_after_accept got=%0b want=0", name, obs_valid);
        end
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_after_accept got=%0b want=1", name, obs_ready);
        end
    endtask

    task automatic check_idle(input string name);
        checks += 6;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s out_valid got=%0b want=0", name, obs_valid);
        end
        if (obs_mode !== 0) begin
            errors++;
            $display("FAIL %s out_mode got=%0d want=0", name, obs_mode);
        end
        if (obs_count !== 0) begin
            errors++;
            $display("FAIL %s out_count got=%0d want=0", name, obs_count);
        end
        if (obs_len !== 0) begin
            errors++;
            $display("FAIL %s out_len got=%0d want=0", name, obs_len);
        end
        if (obs_tie !== 1'b0) begin
            errors++;
            $display("FAIL %s out_tie got=%0b want=0", name, obs_tie);
        end
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready got=%0b want=1", name, obs_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        big = 1'b0;
        #1;
        check_idle("reset_a");
        big = 1'b1;
        #1;
        check_idle("reset_b");
        big = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_release");
    endtask

    task automatic test_full_frame();
        int f[$];
        f = '{3, 1, 1, 2, 1, 0, 3, 1};
        send_frame(f, 1'b0);
        collect(1'b1, "full_frame");
    endtask

    task automatic test_tie();
        int f[$];
        f = '{0, 2, 2, 0, 3, 3, 1, 1};
        send_frame(f, 1'b0);
        collect(1'b1, "tie");
    endtask

    task automatic test_short();
        int f[$];
        f = '{2, 2, 3};
        send_frame(f, 1'b1);
        collect(1'b1, "short");
    endtask

    task automatic test_backpressure();
        int f[$];
        int k = 0;
        int m0, c0, l0;
        logic t0;
        f = '{0, 1, 1, 0, 1, 2, 3, 3};
        send_frame(f, 1'b0);
        while (!obs_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        m0 = obs_mode;
        c0 = obs_count;
        l0 = obs_len;
        t0 = obs_tie;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (!obs_valid || obs_ready || obs_mode != m0 || obs_count != c0 || obs_len != l0
                || obs_tie != t0) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d got=v%0b r%0b m%0d c%0d l%0d t%0b want=v1 r0 m%0d c%0d l%0d t%0b",
                         i, obs_valid, obs_ready, obs_mode, obs_count, obs_len, obs_tie,
                         m0, c0, l0, t0);
            end
        end
        collect(1'b0, "backpressure");
        f = '{1, 1, 1};
        send_frame(f, 1'b1);
        collect(1'b1, "after_backpressure");
    endtask

    task automatic test_clr();
        int f[$];
        f = '{0, 0, 0, 0, 1};
        foreach (f[i]) send_sym(f[i], 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 3'd0;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        check_idle("after_clr");
        f = '{3, 3, 3, 3, 3, 3, 3, 3};
        send_frame(f, 1'b0);
        collect(1'b1, "clr_then_frame");
    endtask

    task automatic test_rst_mid_scan(input string name);
        int f[$];
        int seen = 0;
        f = '{1, 1};
        foreach (f[i]) send_sym(f[i], i == 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_idle(name);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * nb; i++) begin
            @(negedge clk);
            if (obs_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL %s valid_after_reset got=%0d want=0", name, seen);
        end
        check_idle(name);
        f = '{2};
        send_frame(f, 1'b1);
        collect(1'b1, name);
    endtask

    task automatic test_random_big();
        int f[$];
        int n;
        big = 1'b1;
        nb  = 8;
        @(negedge clk);
        test_rst_mid_scan("rst_mid_scan_b");
        for (int r = 0; r < 8; r++) begin
            f.delete();
            n = (r == 0) ? 20 : int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) f.push_back(int'($urandom_range(0, 7)));
            send_frame(f, (n < 20) || (r % 2 == 1));
            collect(1'b1, "random_b");
        end
    endtask

    initial begin
        big       = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_tie();
        test_short();
        test_backpressure();
        test_clr();
        test_rst_mid_scan("rst_mid_scan_a");
        test_random_big();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
